// File: rtl/chan_mux_rr.sv
// chan_mux_rr
//
// Registered N-channel multiplexer with per-channel valid/ready handshakes.
// A combinational one-hot grant picks one producer each cycle, either
// round-robin from PTR or a forced channel (MODE=1, SEL). The selected word
// is captured in a single output register (one cycle latency, full
// throughput). PTR always moves to the channel after the last one served,
// so round-robin resumes fairly after forced mode.
//
// Optional feature, enabled by defining CHAN_MUX_RR_LAST_EN:
//   packet lock. IN_LAST/OUT_LAST ports are added; once a channel sends a
//   non-LAST word it keeps the grant until its LAST word, ignoring
//   MODE/SEL, and PTR only moves on LAST transfers.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   IN_DATA    in   N_CH*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   IN_VALID   in   N_CH per-channel valid
//   IN_READY   out  N_CH per-channel ready, one-hot or zero
//   MODE       in   0 = round-robin, 1 = forced channel
//   SEL        in   SW forced channel index (out of range grants nothing)
//   IN_LAST    in   N_CH end-of-packet markers (CHAN_MUX_RR_LAST_EN only)
//   OUT_DATA   out  WIDTH registered data
//   OUT_VALID  out  registered valid
//   OUT_READY  in   consumer ready
//   OUT_SEL    out  SW index of the channel that supplied OUT_DATA
//   OUT_LAST   out  registered LAST flag (CHAN_MUX_RR_LAST_EN only)
module chan_mux_rr #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8,
   parameter int SW    = $clog2(N_CH)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [N_CH*WIDTH-1:0] IN_DATA,
   input  logic [N_CH-1:0]       IN_VALID,
   output logic [N_CH-1:0]       IN_READY,
   input  logic                  MODE,
   input  logic [SW-1:0]         SEL,
`ifdef CHAN_MUX_RR_LAST_EN
   input  logic [N_CH-1:0]       IN_LAST,
   output logic                  OUT_LAST,
`endif
   output logic [WIDTH-1:0]      OUT_DATA,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [SW-1:0]         OUT_SEL
);

   logic [SW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [SW-1:0]    out_sel_q, out_sel_d;

`ifdef CHAN_MUX_RR_LAST_EN
   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
   lock_state_t      lock_state_q, lock_state_d;
   logic [SW-1:0]    lock_ch_q, lock_ch_d;
   logic             out_last_q, out_last_d;
`endif

   logic             load_en;
   logic             gnt_any;
   logic [SW-1:0]    gnt_idx;
   logic             xfer;
   logic [WIDTH-1:0] data_sel;
   logic [SW-1:0]    ptr_next;

   assign load_en = !out_valid_q || OUT_READY;

   // Grant selection. Descending loops make the last hit the lowest index;
   // in round-robin the second loop (channels >= PTR) overrides the
   // wrap-around candidates below PTR, giving the PTR, PTR+1, ... order.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
`ifdef CHAN_MUX_RR_LAST_EN
      if (lock_state_q == LOCKED) begin
         for (int i = 0; i < N_CH; i++) begin
            if (lock_ch_q == SW'(i) && IN_VALID[i]) begin
               gnt_any = 1'b1;
               gnt_idx = SW'(i);
            end
         end
      end else
`endif
      if (MODE) begin
         for (int i = 0; i < N_CH; i++) begin
            if (SEL == SW'(i) && IN_VALID[i]) begin
               gnt_any = 1'b1;
               gnt_idx = SW'(i);
            end
         end
      end else begin
         for (int i = N_CH - 1; i >= 0; i--) begin
            if (IN_VALID[i] && SW'(i) < ptr_q) begin
               gnt_any = 1'b1;
               gnt_idx = SW'(i);
            end
         end
         for (int i = N_CH - 1; i >= 0; i--) begin
            if (IN_VALID[i] && SW'(i) >= ptr_q) begin
               gnt_any = 1'b1;
               gnt_idx = SW'(i);
            end
         end
      end
   end

   // Ready is forced low during reset so no producer sees a handshake.
   always_comb begin
      IN_READY = '0;
      if (load_en && gnt_any && !RST) begin
         for (int i = 0; i < N_CH; i++) begin
            IN_READY[i] = (gnt_idx == SW'(i));
         end
      end
   end

   assign xfer = load_en && gnt_any && !RST;

   always_comb begin
      data_sel = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (gnt_idx == SW'(i)) data_sel = IN_DATA[i*WIDTH +: WIDTH];
      end
   end

   // Explicit wrap so non-power-of-2 N_CH never reaches N_CH.
   assign ptr_next = (gnt_idx == SW'(N_CH - 1)) ? '0 : gnt_idx + SW'(1);

   always_comb begin
      ptr_d       = ptr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_sel_d   = out_sel_q;
`ifdef CHAN_MUX_RR_LAST_EN
      lock_state_d = lock_state_q;
      lock_ch_d    = lock_ch_q;
      out_last_d   = out_last_q;
`endif
      if (load_en) begin
         if (xfer) begin
            out_data_d  = data_sel;
            out_sel_d   = gnt_idx;
            out_valid_d = 1'b1;
`ifdef CHAN_MUX_RR_LAST_EN
            out_last_d = IN_LAST[gnt_idx];
            if (IN_LAST[gnt_idx]) begin
               ptr_d        = ptr_next;
               lock_state_d = UNLOCKED;
            end else if (lock_state_q == UNLOCKED) begin
               lock_state_d = LOCKED;
               lock_ch_d    = gnt_idx;
            end
`else
            ptr_d = ptr_next;
`endif
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sel_q   <= '0;
`ifdef CHAN_MUX_RR_LAST_EN
         lock_state_q <= UNLOCKED;
         lock_ch_q    <= '0;
         out_last_q   <= 1'b0;
`endif
      end else begin
         ptr_q       <= ptr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_sel_q   <= out_sel_d;
`ifdef CHAN_MUX_RR_LAST_EN
         lock_state_q <= lock_state_d;
         lock_ch_q    <= lock_ch_d;
         out_last_q   <= out_last_d;
`endif
      end
   end

   assign OUT_DATA  = out_data_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_SEL   = out_sel_q;
`ifdef CHAN_MUX_RR_LAST_EN
   assign OUT_LAST  = out_last_q;
`endif

endmodule

// File: tb/tb_chan_mux_rr.sv
// tb_chan_mux_rr
//
// Bench for chan_mux_rr in its default build (packet lock disabled).
// Instance u_dut: N_CH=4, WIDTH=8, tracked every cycle by a behavioural
// model (integer pointer, modulo search). Instance u_dut3: N_CH=3 for the
// non-power-of-2 wrap and out-of-range SEL cases.
module tb_chan_mux_rr;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic        mode;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_sel;

   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic        mode3;
   logic [1:0]  sel3;
   logic [7:0]  out_data3;
   logic        out_valid3;
   logic        out_ready3;
   logic [1:0]  out_sel3;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int         m_ptr;
   logic       m_valid;
   logic [7:0] m_data;
   int         m_sel;

   always #5 clk = ~clk;

   chan_mux_rr #(.N_CH(4), .WIDTH(8)) u_dut (
      .CLK(clk), .RST(rst),
      .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
      .MODE(mode), .SEL(sel),
      .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .OUT_SEL(out_sel)
   );

   chan_mux_rr #(.N_CH(3), .WIDTH(8)) u_dut3 (
      .CLK(clk), .RST(rst),
      .IN_DATA(in_data3), .IN_VALID(in_valid3), .IN_READY(in_ready3),
      .MODE(mode3), .SEL(sel3),
      .OUT_DATA(out_data3), .OUT_VALID(out_valid3), .OUT_READY(out_ready3),
      .OUT_SEL(out_sel3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge with inputs already driven: checks the
   // combinational ready, advances the model over the rising edge and checks
   // the registered outputs at the next falling edge.
   task automatic step();
      int         g;
      logic       load;
      logic [3:0] exp_rdy;
      #1;
      load = !m_valid || out_ready;
      g = -1;
      if (mode) begin
         if (int'(sel) < 4 && in_valid[sel]) g = int'(sel);
      end else begin
         for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (g < 0 && in_valid[c]) g = c;
         end
      end
      exp_rdy = (rst || !load || g < 0) ? 4'b0000 : 4'(1 << g);
      chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
      @(posedge clk);
      if (rst) begin
         m_ptr = 0; m_valid = 1'b0; m_data = 8'h00; m_sel = 0;
      end else if (load) begin
         if (g >= 0) begin
            m_data  = in_data[g*8 +: 8];
            m_sel   = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % 4;
         end else begin
            m_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("out_data", {24'd0, out_data}, {24'd0, m_data});
      chk("out_sel", {30'd0, out_sel}, 32'(m_sel));
   endtask

   initial begin
      rst = 1'b1; in_data = 32'h0D0C0B0A; in_valid = 4'hF; mode = 1'b0; sel = 2'd0;
      out_ready = 1'b1;
      in_data3 = 24'h323130; in_valid3 = 3'b000; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
      m_ptr = 0; m_valid = 1'b0; m_data = 8'h00; m_sel = 0;

      // reset state, IN_READY zero while RST high even with all channels valid
      @(negedge clk);
      step();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", {24'd0, out_data}, 32'd0);
      chk("rst_sel", {30'd0, out_sel}, 32'd0);
      chk("rst_ready", {28'd0, in_ready}, 32'd0);
      rst = 1'b0;

      // round-robin, all channels valid
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_sel", {30'd0, out_sel}, 32'(k % 4));
         chk("rr_data", {24'd0, out_data}, 32'(8'h0A + k % 4));
         chk("rr_valid", {31'd0, out_valid}, 32'd1);
      end

      // forced channel 2
      mode = 1'b1; sel = 2'd2;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("force_data", {24'd0, out_data}, 32'h0C);
         chk("force_ready", {28'd0, in_ready}, 32'b0100);
      end
      sel = 2'd3; in_valid = 4'b0100;
      step();
      chk("force_drop", {31'd0, out_valid}, 32'd0);

      // backpressure after loading 0x0B
      sel = 2'd1; in_valid = 4'hF;
      step();
      chk("bp_load", {24'd0, out_data}, 32'h0B);
      mode = 1'b0; out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_data", {24'd0, out_data}, 32'h0B);
         chk("bp_sel", {30'd0, out_sel}, 32'd1);
         chk("bp_ready", {28'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      step();
      chk("bp_next", {24'd0, out_data}, 32'h0C);
      step();
      chk("bp_after", {24'd0, out_data}, 32'h0D);

      // reset with a stalled word pending
      out_ready = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_data", {24'd0, out_data}, 32'd0);
      chk("mid_rst_sel", {30'd0, out_sel}, 32'd0);
      rst = 1'b0; out_ready = 1'b1;
      step();
      chk("post_rst_sel", {30'd0, out_sel}, 32'd0);
      chk("post_rst_data", {24'd0, out_data}, 32'h0A);

      // N_CH=3 instance: wrap with channels 1 and 2, then pointer back at 0
      in_valid = 4'h0;
      in_valid3 = 3'b110;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("w3_ready", {29'd0, in_ready3}, (k % 2 == 0) ? 32'b010 : 32'b100);
         step();
         chk("w3_sel", {30'd0, out_sel3}, (k % 2 == 0) ? 32'd1 : 32'd2);
         chk("w3_data", {24'd0, out_data3}, (k % 2 == 0) ? 32'h31 : 32'h32);
      end
      in_valid3 = 3'b111;
      #1;
      chk("w3_wrap_ready", {29'd0, in_ready3}, 32'b001);
      step();
      chk("w3_wrap_sel", {30'd0, out_sel3}, 32'd0);
      mode3 = 1'b1; sel3 = 2'd3;
      #1;
      chk("w3_oor_ready", {29'd0, in_ready3}, 32'd0);
      step();
      chk("w3_oor_valid", {31'd0, out_valid3}, 32'd0);
      sel3 = 2'd2;
      step();
      chk("w3_force_sel", {30'd0, out_sel3}, 32'd2);
      chk("w3_force_valid", {31'd0, out_valid3}, 32'd1);
      in_valid3 = 3'b000;

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         in_data   = $urandom;
         in_valid  = 4'($urandom);
         mode      = ($urandom % 4 == 0);
         sel       = 2'($urandom);
         out_ready = ($urandom % 4 != 0);
         rst       = ($urandom % 50 == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
